// File: rtl/hub75_pkg.sv
// hub75_pkg: shared state encoding, pixel field layout and default panel geometry
package hub75_pkg;
    localparam int COLS_DEF      = 64;
    localparam int ROW_PAIRS_DEF = 16;
    localparam int BITS_DEF      = 8;
    localparam int BASE_TIME_DEF = 32;
    localparam int FIELD_W       = 8;
    localparam int R_LSB         = 16;
    localparam int G_LSB         = 8;
    localparam int B_LSB         = 0;
    typedef enum logic [2:0] {
        IDLE, RD_TOP, RD_BOT, SETUP, CLK, BLANK, LATCH, SHOW
    } state_t;
endpackage

// File: rtl/hub75_scan_driver_bcm_timer.sv
// bcm_timer: loadable down-counter timing the lit period of one bit plane
module bcm_timer
    import hub75_pkg::*;
#(
    parameter int BASE_TIME = BASE_TIME_DEF,
    parameter int BITS      = BITS_DEF,
    localparam int PW       = $clog2(BITS),
    localparam int CNT_W    = $clog2(BASE_TIME) + BITS
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [PW-1:0] plane,
    output logic          done
);
    logic [CNT_W-1:0] cnt;
    // load the binary-weighted duration, then count down to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= CNT_W'(BASE_TIME) << plane;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end
    assign done = cnt == CNT_W'(1);
endmodule

// File: rtl/hub75_scan_driver.sv
// hub75_scan_driver: BCM scan engine reading a framebuffer and driving a HUB75 panel
module hub75_scan_driver
    import hub75_pkg::*;
#(
    parameter int COLS      = COLS_DEF,
    parameter int ROW_PAIRS = ROW_PAIRS_DEF,
    parameter int BITS      = BITS_DEF,
    parameter int BASE_TIME = BASE_TIME_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic        rd_en,
    output logic [11:0] rd_addr,
    input  logic [23:0] rd_data,
    output logic        r0,
    output logic        g0,
    output logic        b0,
    output logic        r1,
    output logic        g1,
    output logic        b1,
    output logic [3:0]  row_addr,
    output logic        pclk,
    output logic        lat,
    output logic        oe_n,
    output logic        frame_done
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROW_PAIRS);
    localparam int PW = $clog2(BITS);

    state_t        state, next;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [PW-1:0] plane;
    logic [2:0]    top_pix, bot_pix;
    logic [3:0]    row_q;
    logic          show_done, last_col, last_row, last_plane, frame_end;
    logic [FIELD_W-1:0] r_f, g_f, b_f;
    logic [2:0]    pix_bit;

    assign last_col   = col == CW'(COLS - 1);
    assign last_row   = row == RW'(ROW_PAIRS - 1);
    assign last_plane = plane == PW'(BITS - 1);
    assign frame_end  = last_row && last_plane;
    assign r_f        = rd_data[R_LSB +: FIELD_W];
    assign g_f        = rd_data[G_LSB +: FIELD_W];
    assign b_f        = rd_data[B_LSB +: FIELD_W];
    assign pix_bit    = {r_f[plane], g_f[plane], b_f[plane]};
    assign {r0, g0, b0} = top_pix;
    assign {r1, g1, b1} = bot_pix;
    assign row_addr     = row_q;

    bcm_timer #(
        .BASE_TIME(BASE_TIME),
        .BITS(BITS)
    ) u_timer (
        .clk(clk),
        .rst_n(rst_n),
        .load(state == LATCH),
        .plane(plane),
        .done(show_done)
    );

    // state register; reset drops straight to IDLE so the panel blanks immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next;
    end

    // next state and all strobes decoded from the current state
    always_comb begin
        next       = state;
        rd_en      = state == RD_TOP || state == RD_BOT;
        rd_addr    = state == RD_TOP ? 12'(row) * 12'(COLS) + 12'(col) :
                     state == RD_BOT ? (12'(row) + 12'(ROW_PAIRS)) * 12'(COLS) + 12'(col) : '0;
        pclk       = state == CLK;
        lat        = state == LATCH;
        oe_n       = state != SHOW;
        frame_done = state == SHOW && show_done && frame_end;
        case (state)
            IDLE:    next = enable ? RD_TOP : IDLE;
            RD_TOP:  next = RD_BOT;
            RD_BOT:  next = SETUP;
            SETUP:   next = CLK;
            CLK:     next = last_col ? BLANK : RD_TOP;
            BLANK:   next = LATCH;
            LATCH:   next = SHOW;
            SHOW:    next = !show_done ? SHOW : (frame_end && !enable) ? IDLE : RD_TOP;
            default: next = IDLE;
        endcase
    end

    // column/plane/row position, captured pixel bits and the latched row select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col     <= '0;
            row     <= '0;
            plane   <= '0;
            top_pix <= '0;
            bot_pix <= '0;
            row_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    col   <= '0;
                    row   <= '0;
                    plane <= '0;
                end
                RD_BOT: top_pix <= pix_bit;
                SETUP:  bot_pix <= pix_bit;
                CLK:    if (!last_col) col <= col + 1'b1;
                BLANK:  row_q <= 4'(row);
                SHOW: if (show_done) begin
                    col   <= '0;
                    plane <= last_plane ? '0 : plane + 1'b1;
                    if (last_plane) row <= last_row ? '0 : row + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hub75_scan_driver.sv
// tb_hub75_scan_driver: directed checks of scan timing, addressing, BCM weights, frame end and reset
module tb_hub75_scan_driver;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        rd_en;
    logic [11:0] rd_addr;
    logic [23:0] rd_data = '0;
    logic        r0, g0, b0, r1, g1, b1;
    logic [3:0]  row_addr;
    logic        pclk, lat, oe_n, frame_done;

    logic        rst_n_b = 1'b0;
    logic        enable_b = 1'b0;
    logic        rd_en_b;
    logic [11:0] rd_addr_b;
    logic [23:0] rd_data_b = '0;
    logic        r0_b, g0_b, b0_b, r1_b, g1_b, b1_b;
    logic [3:0]  row_addr_b;
    logic        pclk_b, lat_b, oe_n_b, frame_done_b;

    logic [23:0] mem [4096];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    hub75_scan_driver dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
        .row_addr(row_addr), .pclk(pclk), .lat(lat), .oe_n(oe_n), .frame_done(frame_done)
    );

    hub75_scan_driver #(.COLS(4), .ROW_PAIRS(16), .BITS(8), .BASE_TIME(1)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .enable(enable_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
        .rd_data(rd_data_b), .r0(r0_b), .g0(g0_b), .b0(b0_b), .r1(r1_b), .g1(g1_b), .b1(b1_b),
        .row_addr(row_addr_b), .pclk(pclk_b), .lat(lat_b), .oe_n(oe_n_b), .frame_done(frame_done_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_slot(input string tag, input logic [5:0] exp_rgb, input int exp_show,
                            input logic [3:0] exp_row);
        int pclks = 0, good = 0, lats = 0, show = 0, bad = 0;
        logic [3:0] row_seen = '0;
        bit fin = 0;
        for (int i = 0; i < 6000 && !fin; i++) begin
            @(negedge clk);
            if (pclk) begin
                pclks++;
                if ({r0, g0, b0, r1, g1, b1} == exp_rgb) good++;
            end
            if (lat) begin
                lats++;
                row_seen = row_addr;
            end
            if (rd_en && (lat || !oe_n || pclk)) bad++;
            if (!oe_n) show++;
            else if (show > 0) fin = 1;
        end
        chk({tag, "_done"}, 32'(fin), 1);
        chk({tag, "_pclk"}, pclks, 64);
        chk({tag, "_rgb"}, good, 64);
        chk({tag, "_lat"}, lats, 1);
        chk({tag, "_row"}, 32'(row_seen), 32'(exp_row));
        chk({tag, "_show"}, show, exp_show);
        chk({tag, "_excl"}, bad, 0);
    endtask

    initial begin
        int lats, fds, rds;
        bit fin;
        for (int a = 0; a < 4096; a++) mem[a] = 24'hFF0000;
        repeat (3) @(negedge clk);
        chk("rst_oe_n", 32'(oe_n), 1);
        chk("rst_lat", 32'(lat), 0);
        chk("rst_pclk", 32'(pclk), 0);
        chk("rst_rd_en", 32'(rd_en), 0);
        chk("rst_rd_addr", 32'(rd_addr), 0);
        chk("rst_rgb", 32'({r0, g0, b0, r1, g1, b1}), 0);
        chk("rst_row_addr", 32'(row_addr), 0);
        chk("rst_frame_done", 32'(frame_done), 0);

        enable = 1'b1;
        rst_n = 1'b1;
        run_slot("r0p0", 6'b100100, 32, 4'd0);

        for (int a = 0; a < 4096; a++) mem[a] = 24'h000080;
        mem[197]  = 24'h010100;
        mem[1221] = 24'h000001;
        for (int p = 1; p < 8; p++)
            run_slot($sformatf("r0p%0d", p), p == 7 ? 6'b001001 : 6'b000000, 32 << p, 4'd0);
        for (int r = 1; r < 3; r++)
            for (int p = 0; p < 8; p++)
                run_slot($sformatf("r%0dp%0d", r, p), p == 7 ? 6'b001001 : 6'b000000, 32 << p, 4'(r));

        chk("r3c0_rd_en", 32'(rd_en), 1);
        chk("r3c0_addr", 32'(rd_addr), 192);
        repeat (20) @(negedge clk);
        chk("r3c5_top_en", 32'(rd_en), 1);
        chk("r3c5_top_addr", 32'(rd_addr), 197);
        @(negedge clk);
        chk("r3c5_bot_en", 32'(rd_en), 1);
        chk("r3c5_bot_addr", 32'(rd_addr), 1221);
        @(negedge clk);
        chk("r3c5_setup_pclk", 32'(pclk), 0);
        @(negedge clk);
        chk("r3c5_clk_pclk", 32'(pclk), 1);
        chk("r3c5_rgb", 32'({r0, g0, b0, r1, g1, b1}), 32'(6'b110001));

        fin = 0;
        for (int i = 0; i < 400 && !fin; i++) begin
            @(negedge clk);
            if (!oe_n) fin = 1;
        end
        chk("show_reached", 32'(fin), 1);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midshow_oe_n", 32'(oe_n), 1);
        chk("midshow_lat", 32'(lat), 0);
        chk("midshow_rd_en", 32'(rd_en), 0);
        chk("midshow_pclk", 32'(pclk), 0);
        chk("midshow_rgb", 32'({r0, g0, b0, r1, g1, b1}), 0);
        chk("midshow_row_addr", 32'(row_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_rd_en", 32'(rd_en), 1);
        chk("restart_addr", 32'(rd_addr), 0);

        enable_b = 1'b1;
        rst_n_b = 1'b1;
        lats = 0;
        fds = 0;
        fin = 0;
        for (int i = 0; i < 20000 && !fin; i++) begin
            @(negedge clk);
            if (lat_b) lats++;
            if (lats == 10) enable_b = 1'b0;
            if (frame_done_b) begin
                fds++;
                fin = 1;
            end
        end
        chk("frame_done_seen", 32'(fin), 1);
        chk("frame_slots", lats, 128);
        rds = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rd_en_b) rds++;
            if (frame_done_b) fds++;
        end
        chk("frame_done_pulses", fds, 1);
        chk("idle_rd_en", rds, 0);
        chk("idle_oe_n", 32'(oe_n_b), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
